nios_dut_pio_out: RTL and testbench
===================================

NIOS_DUT_PIO_OUT -- requirements
Module: nios_dut_pio_out

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, meaning output port width (1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the value loaded into the data register on reset.
REQ-003 The block SHALL have parameter PULSE_LEN, default 16, meaning the pulse duration in clk cycles (legal range 1..65535).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-007 The block SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-008 The block SHALL have port address, input, 3 bits: word address.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port out_port, output, WIDTH bits: the driven outputs.
REQ-012 The block SHALL have port out_update, output, 1 bit: one-cycle strobe after each accepted register write.

Function
REQ-013 Write accept: chipselect=1 and write_n=0 on a rising clk edge; one write per cycle max.
REQ-014 Address 0 write: data_reg <= writedata[WIDTH-1:0]; bits above WIDTH are ignored.
REQ-015 Address 4 write (outset): data_reg <= data_reg | writedata[WIDTH-1:0].
REQ-016 Address 5 write (outclear): data_reg <= data_reg & ~writedata[WIDTH-1:0].
REQ-017 Writes to addresses 1, 3, 6 and 7 SHALL have no effect and SHALL NOT assert out_update.
REQ-018 out_port = data_reg | pulse_mask, both registered, so out_port changes in the cycle following the accepting edge.
REQ-019 out_update SHALL be high for exactly one cycle after each accepted write to address 0/4/5 (or 2 when pulse is enabled), even when the value is unchanged.
REQ-020 readdata SHALL be registered every cycle (1-cycle latency, chipselect not required): address 0 -> zero-extended data_reg; address 2 -> zero-extended pulse_mask (pulse enabled) else 0; all other addresses -> 0.
REQ-021 A read in the same cycle as a write to the same register SHALL return the pre-write value.

Reset
REQ-022 On reset=1 at a clk edge: data_reg=RESET_VALUE, pulse_mask=0, pulse counter=0, state=IDLE, readdata=0, out_update=0; out_port=RESET_VALUE in the next cycle.
REQ-023 A reset asserted during an active pulse SHALL abort the pulse immediately, with no residual pulse afterwards.

Configuration
REQ-024 Macro NIOS_DUT_PIO_OUT_PULSE_EN, when defined, SHALL compile in the pulse engine: a 2-state FSM (IDLE, ACTIVE), a 16-bit down-counter, and pulse_mask.
REQ-025 Pulse address 2 write in IDLE with a nonzero mask: pulse_mask <= mask, counter <= PULSE_LEN-1, state goes to ACTIVE; a zero mask SHALL be ignored, but out_update SHALL still assert.
REQ-026 In ACTIVE with counter>0, the counter SHALL decrement each cycle; at counter==0 with no write, pulse_mask SHALL clear and state SHALL return to IDLE, so each pulse bit is high for exactly PULSE_LEN cycles.
REQ-027 Address 2 write in ACTIVE (retrigger): pulse_mask <= pulse_mask | mask and counter <= PULSE_LEN-1; on the same cycle as expiry, the write SHALL win.
REQ-028 Without the macro: address 2 SHALL be unmapped (write ignored, reads 0), pulse_mask SHALL be constant 0, and no counter or FSM flops SHALL exist.

Structure
REQ-029 Register address constants (ADDR_DATA=0, ADDR_PULSE=2, ADDR_OUTSET=4, ADDR_OUTCLR=5) and the pulse state encoding SHALL live in shared package nios_dut_pio_pkg.
REQ-030 The pulse engine SHALL be one sub-module, nios_dut_pio_pulse (inputs: load strobe and mask; outputs: pulse_mask and active); the top holds the register file, read mux and out_update.

Verification
REQ-031 Reset with RESET_VALUE=0x00A5 -> out_port=0x000A5, readdata=0, out_update=0.
REQ-032 Write addr0 0xFFF12345 -> next cycle out_port=0x12345, out_update pulses once; then read addr0 -> readdata=0x00012345 one cycle later.
REQ-033 From 0x12345: outset 0x000F0 -> 0x123F5; then outclear 0x00005 -> 0x123F0; writes to addr 6 -> no change, out_update stays 0.
REQ-034 Pulse enabled, PULSE_LEN=4, data=0: write addr2 0x00001 -> out_port bit0 high exactly 4 cycles, then 0; pulse read during the pulse returns 0x1.
REQ-035 Pulse retrigger: write 0x1, after 2 cycles write 0x2 -> bits {1,0} high for 4 more cycles, then both clear together; a write landing on the expiry cycle extends the pulse.
REQ-036 Reset asserted during a pulse -> pulse_mask=0 next cycle; with the macro undefined, an addr2 write leaves out_port and readdata unchanged.

Source files
------------

// File: rtl/nios_dut_pio_pkg.sv
// Shared register map and pulse-engine encoding for the nios_dut_pio_out PIO block.
package nios_dut_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PULSE  = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int unsigned PULSE_CNT_W = 16;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/nios_dut_pio_pulse.sv
// Timed pulse engine: holds a mask high for PULSE_LEN cycles; a load while active ORs in the new mask and restarts the timer.
module nios_dut_pio_pulse
    import nios_dut_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 20,
    parameter int unsigned PULSE_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] pulse_mask,
    output logic             active
);

    localparam logic [PULSE_CNT_W-1:0] CNT_LOAD = PULSE_CNT_W'(PULSE_LEN - 1);

    pulse_state_e             state_q, state_d;
    logic [PULSE_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]         mask_q, mask_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PULSE_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    // A load landing on the expiry cycle takes priority over the clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            PULSE_IDLE: begin
                if (load && (mask != '0)) begin
                    mask_d  = mask;
                    cnt_d   = CNT_LOAD;
                    state_d = PULSE_ACTIVE;
                end
            end
            PULSE_ACTIVE: begin
                if (load) begin
                    mask_d = mask_q | mask;
                    cnt_d  = CNT_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - PULSE_CNT_W'(1);
                end else begin
                    mask_d  = '0;
                    state_d = PULSE_IDLE;
                end
            end
            default: begin
                mask_d  = '0;
                cnt_d   = '0;
                state_d = PULSE_IDLE;
            end
        endcase
    end

    assign pulse_mask = mask_q;
    assign active     = (state_q == PULSE_ACTIVE);

endmodule

// File: rtl/nios_dut_pio_out.sv
// Avalon-MM output PIO with data/outset/outclear registers and registered read-back.
// Optional timed pulse register at address 2 is compiled in by NIOS_DUT_PIO_OUT_PULSE_EN.
module nios_dut_pio_out
    import nios_dut_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 20,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int unsigned PULSE_LEN   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             out_update
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             out_update_q, out_update_d;
    logic [WIDTH-1:0] pulse_mask;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

`ifdef NIOS_DUT_PIO_OUT_PULSE_EN
    logic pulse_load;
    logic pulse_active;

    nios_dut_pio_pulse #(
        .WIDTH     (WIDTH),
        .PULSE_LEN (PULSE_LEN)
    ) u_pulse (
        .clk        (clk),
        .reset      (reset),
        .load       (pulse_load),
        .mask       (wdata),
        .pulse_mask (pulse_mask),
        .active     (pulse_active)
    );

    logic unused_pulse_active;
    assign unused_pulse_active = pulse_active;
`else
    assign pulse_mask = '0;
`endif

    if (WIDTH < 32) begin : g_unused_wdata
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[31:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= WIDTH'(RESET_VALUE);
            readdata_q   <= '0;
            out_update_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            readdata_q   <= readdata_d;
            out_update_q <= out_update_d;
        end
    end

    // Register writes; unmapped addresses neither change state nor strobe out_update.
    always_comb begin
        data_d       = data_q;
        out_update_d = 1'b0;
`ifdef NIOS_DUT_PIO_OUT_PULSE_EN
        pulse_load   = 1'b0;
`endif
        if (wr_en) begin
            case (address)
                ADDR_DATA: begin
                    data_d       = wdata;
                    out_update_d = 1'b1;
                end
                ADDR_OUTSET: begin
                    data_d       = data_q | wdata;
                    out_update_d = 1'b1;
                end
                ADDR_OUTCLR: begin
                    data_d       = data_q & ~wdata;
                    out_update_d = 1'b1;
                end
`ifdef NIOS_DUT_PIO_OUT_PULSE_EN
                ADDR_PULSE: begin
                    pulse_load   = 1'b1;
                    out_update_d = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Read mux samples the current (pre-write) register values.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:  readdata_d = 32'(data_q);
`ifdef NIOS_DUT_PIO_OUT_PULSE_EN
            ADDR_PULSE: readdata_d = 32'(pulse_mask);
`endif
            default:    readdata_d = '0;
        endcase
    end

    assign readdata   = readdata_q;
    assign out_update = out_update_q;
    assign out_port   = data_q | pulse_mask;

endmodule

// File: tb/tb_nios_dut_pio_out.sv
// Bench for nios_dut_pio_out: cycle model with remaining-cycle pulse bookkeeping plus directed literal checks.
module tb_nios_dut_pio_out;

    localparam int unsigned WIDTH     = 20;
    localparam logic [31:0] RV        = 32'h0000_00A5;
    localparam int unsigned PULSE_LEN = 4;
    localparam logic [31:0] WMASK     = 32'h000F_FFFF;
`ifdef NIOS_DUT_PIO_OUT_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [2:0]       address = 3'd0;
    logic [31:0]      writedata = 32'd0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             out_update;

    int n_cmp  = 0;
    int n_fail = 0;

    nios_dut_pio_out #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .PULSE_LEN   (PULSE_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_update (out_update)
    );

    always #5 clk = ~clk;

    // Model: data word, pulse mask and number of cycles the pulse still has to stay visible.
    logic [31:0] m_data, m_pmask, m_rd;
    logic        m_upd;
    int          m_rem;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        logic [31:0] new_rd;
        logic [31:0] m;
        bit          wr, pwr;
        if (reset) begin
            m_data  = RV & WMASK;
            m_pmask = 0;
            m_rem   = 0;
            m_rd    = 0;
            m_upd   = 0;
            m_valid = 1'b1;
        end else begin
            wr     = chipselect && !write_n;
            m      = writedata & WMASK;
            new_rd = (address == 3'd0) ? m_data : ((PULSE && address == 3'd2) ? m_pmask : 32'd0);
            m_upd  = 0;
            pwr    = 0;
            if (wr) begin
                if (address == 3'd0)      begin m_data = m;            m_upd = 1; end
                else if (address == 3'd4) begin m_data = m_data | m;   m_upd = 1; end
                else if (address == 3'd5) begin m_data = m_data & ~m;  m_upd = 1; end
                else if (address == 3'd2 && PULSE) begin pwr = 1;      m_upd = 1; end
            end
            if (pwr && (m_rem > 0 || m != 0)) begin
                m_pmask = (m_rem > 0) ? (m_pmask | m) : m;
                m_rem   = PULSE_LEN;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_pmask = 0;
            end
            m_rd = new_rd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model out_port",   32'(out_port),   m_data | m_pmask);
            chk("model readdata",   readdata,        m_rd);
            chk("model out_update", 32'(out_update), 32'(m_upd));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset out_port",   32'(out_port),   32'h0000_00A5);
        chk("reset readdata",   readdata,        32'h0);
        chk("reset out_update", 32'(out_update), 32'h0);
        reset = 1'b0;

        wr(3'd0, 32'hFFF1_2345);
        chk("addr0 out_port",   32'(out_port),   32'h0001_2345);
        chk("addr0 out_update", 32'(out_update), 32'h1);
        idle(1);
        chk("addr0 strobe once", 32'(out_update), 32'h0);
        chk("addr0 readback",    readdata,        32'h0001_2345);

        wr(3'd4, 32'h0000_00F0);
        chk("outset", 32'(out_port), 32'h0001_23F5);
        wr(3'd5, 32'h0000_0005);
        chk("outclear", 32'(out_port), 32'h0001_23F0);
        wr(3'd6, 32'hFFFF_FFFF);
        chk("addr6 out_port",   32'(out_port),   32'h0001_23F0);
        chk("addr6 out_update", 32'(out_update), 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd7, 32'h0);
        chk("addr1/3/7 out_port",   32'(out_port),   32'h0001_23F0);
        chk("addr1/3/7 out_update", 32'(out_update), 32'h0);

        address = 3'd0;
        idle(1);
        wr(3'd0, 32'h0000_0055);
        chk("read during write is pre-write", readdata, 32'h0001_23F0);
        idle(1);
        chk("read after write", readdata, 32'h0000_0055);

`ifdef NIOS_DUT_PIO_OUT_PULSE_EN
        wr(3'd0, 32'h0);
        wr(3'd2, 32'h0);
        chk("zero pulse strobe", 32'(out_update), 32'h1);
        chk("zero pulse ignored", 32'(out_port), 32'h0);

        wr(3'd2, 32'h0000_0001);
        chk("pulse cycle 1", 32'(out_port), 32'h1);
        for (int i = 2; i <= 4; i++) begin
            idle(1);
            chk("pulse held", 32'(out_port), 32'h1);
        end
        chk("pulse readback", readdata, 32'h1);
        idle(1);
        chk("pulse ended", 32'(out_port), 32'h0);

        wr(3'd2, 32'h0000_0001);
        idle(1);
        wr(3'd2, 32'h0000_0002);
        for (int i = 1; i <= 4; i++) begin
            chk("retrigger held", 32'(out_port), 32'h3);
            idle(1);
        end
        chk("retrigger both clear", 32'(out_port), 32'h0);

        wr(3'd2, 32'h0000_0001);
        idle(3);
        wr(3'd2, 32'h0000_0004);
        for (int i = 1; i <= 4; i++) begin
            chk("expiry write extends", 32'(out_port), 32'h5);
            idle(1);
        end
        chk("extended pulse ended", 32'(out_port), 32'h0);

        wr(3'd2, 32'h0000_0008);
        reset = 1'b1;
        idle(1);
        chk("reset aborts pulse", 32'(out_port), 32'h0000_00A5);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("no residual pulse", 32'(out_port), 32'h0000_00A5);
        end
`else
        address = 3'd2;
        wr(3'd2, 32'h000F_FFFF);
        chk("addr2 unmapped out_port",   32'(out_port),   32'h0000_0055);
        chk("addr2 unmapped out_update", 32'(out_update), 32'h0);
        idle(1);
        chk("addr2 reads zero", readdata, 32'h0);
        reset = 1'b1;
        idle(1);
        chk("re-reset out_port", 32'(out_port), 32'h0000_00A5);
        reset = 1'b0;
        idle(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
